// File: rtl/instruction_prefetch_unit.sv
// Instruction prefetch unit: decoupled fetch front end for the turtle core.
// Issues in-order pipelined requests to an instruction memory of arbitrary
// latency. Returned instructions are buffered with their PC in a small queue.
// A valid/ready handshake presents them to the decoder.
// A redirect flushes the queue and discards responses that are still in flight.
// Optional build macro: PREFETCH_PERF_COUNTERS_EN. It adds the saturating
// counters perf_stall_cycles and perf_killed_rsp.
module instruction_prefetch_unit #(
    parameter int unsigned          I_ADDR_W        = 12,
    parameter int unsigned          INST_W          = 16,
    parameter int unsigned          INST_W_BYTES    = (INST_W + 7) / 8,
    parameter int unsigned          DEPTH           = 4,
    parameter int unsigned          MAX_OUTSTANDING = 2,
    parameter logic [I_ADDR_W-1:0]  RESET_PC        = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid,
    input  logic [I_ADDR_W-1:0] redirect_addr,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [I_ADDR_W-1:0] mem_req_addr,
    input  logic                mem_rsp_valid,
    input  logic [INST_W-1:0]   mem_rsp_data,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [INST_W-1:0]   inst_data,
    output logic [I_ADDR_W-1:0] inst_pc
`ifdef PREFETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]         perf_stall_cycles,
    output logic [31:0]         perf_killed_rsp
`endif
);

    // Widths of the queue pointers and of the occupancy counters.
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    // count + outstanding + kill can reach DEPTH + 2*MAX_OUTSTANDING <= 3*DEPTH.
    localparam int unsigned SUM_W = CNT_W + 2;

    localparam logic [I_ADDR_W-1:0] ADDR_STEP  = I_ADDR_W'(INST_W_BYTES);
    localparam logic [I_ADDR_W-1:0] ALIGN_MASK = ~(I_ADDR_W'(INST_W_BYTES - 1));

    // Architectural fetch state.
    logic [I_ADDR_W-1:0] fetch_pc;
    logic [I_ADDR_W-1:0] rsp_pc;

    // Instruction queue storage and bookkeeping.
    logic [INST_W-1:0]   data_mem [DEPTH];
    logic [I_ADDR_W-1:0] pc_mem   [DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [CNT_W-1:0]    count;

    // Requests accepted by memory but not yet answered, and how many of
    // those belong to a flushed stream and must be thrown away on return.
    logic [OUT_W-1:0]    outstanding;
    logic [OUT_W-1:0]    kill;

    // Per-cycle control decisions.
    logic [SUM_W-1:0]    credit_sum;
    logic                issue_ok;
    logic                req_fire;
    logic                rsp_drop;
    logic                push;
    logic                pop;
    logic [OUT_W-1:0]    outstanding_nxt;
    logic [I_ADDR_W-1:0] redirect_aligned;

    // Issue, drop and queue handshake decisions for the current cycle.
    always_comb begin
        credit_sum = SUM_W'(count) + SUM_W'(outstanding) + SUM_W'(kill);
        // A queue slot is reserved for every request in flight. Responses
        // that will be killed also hold a slot. So a response can always be
        // pushed, and memory never needs back-pressure.
        issue_ok = !rst && !redirect_valid
                   && (outstanding < OUT_W'(MAX_OUTSTANDING))
                   && (credit_sum < SUM_W'(DEPTH));
        req_fire = issue_ok && mem_req_ready;
        // A response is dropped if it belongs to a killed stream, or if it
        // arrives in the same cycle as a redirect.
        rsp_drop = mem_rsp_valid && ((kill != '0) || redirect_valid);
        push     = mem_rsp_valid && (kill == '0) && !redirect_valid;
        pop      = inst_valid && inst_ready;
        outstanding_nxt  = outstanding + OUT_W'(req_fire) - OUT_W'(mem_rsp_valid);
        redirect_aligned = redirect_addr & ALIGN_MASK;
    end

    // Drive the memory request channel and the decoder channel.
    always_comb begin
        mem_req_valid = issue_ok;
        mem_req_addr  = fetch_pc;
        inst_valid    = !rst && (count != '0);
        inst_data     = data_mem[rd_ptr];
        inst_pc       = pc_mem[rd_ptr];
    end

    // Fetch address, response address, pointers and credit counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            kill        <= '0;
        end else if (redirect_valid) begin
            // Any pop in this cycle is absorbed by the flush. Every request
            // still in flight after this cycle's response is marked for kill.
            fetch_pc    <= redirect_aligned;
            rsp_pc      <= redirect_aligned;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= outstanding_nxt;
            kill        <= outstanding_nxt;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + ADDR_STEP;
            end
            outstanding <= outstanding_nxt;
            if (rsp_drop) begin
                kill <= kill - OUT_W'(1);
            end
            if (push) begin
                rsp_pc <= rsp_pc + ADDR_STEP;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Queue storage: write the accepted response at the tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (push) begin
            data_mem[wr_ptr] <= mem_rsp_data;
            pc_mem[wr_ptr]   <= rsp_pc;
        end
    end

`ifdef PREFETCH_PERF_COUNTERS_EN
    // Saturating counters: decoder starvation cycles and discarded responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_killed_rsp   <= '0;
        end else begin
            if (!inst_valid && (perf_stall_cycles != '1)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (rsp_drop && (perf_killed_rsp != '1)) begin
                perf_killed_rsp <= perf_killed_rsp + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/instruction_prefetch_unit.md
Name: instruction_prefetch_unit

Overview:
Decoupled instruction fetch front end that replaces the direct PC-to-instruction-memory path in the turtle core. It issues in-order, pipelined requests to an instruction memory of arbitrary latency and buffers returned instructions in a parametrised queue. Instructions are presented to the decoder through a valid/ready handshake with their PC attached. A redirect input from branch/jump resolution flushes the queue and discards in-flight responses.

Parameters:
I_ADDR_W, 12, instruction byte-address width
INST_W, 16, instruction width in bits
INST_W_BYTES, (INST_W+7)/8, bytes per instruction; must be a power of 2; PC increment
DEPTH, 4, queue entries; power of 2, >= 2
MAX_OUTSTANDING, 2, maximum un-returned memory requests; 1..DEPTH
RESET_PC, 0, fetch address after reset; must be aligned to INST_W_BYTES

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
redirect_valid  in  1  flush and restart fetch, 1-cycle pulse
redirect_addr  in  I_ADDR_W  new fetch address
mem_req_valid  out  1  request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  I_ADDR_W  request byte address
mem_rsp_valid  in  1  response valid; in order; never back-pressured
mem_rsp_data  in  INST_W  returned instruction
inst_valid  out  1  queue head valid
inst_ready  in  1  decoder consumes head
inst_data  out  INST_W  head instruction
inst_pc  out  I_ADDR_W  byte address of head instruction

Behaviour:
- State: fetch_pc, rsp_pc, queue (data+pc, rd/wr pointers, count), outstanding count, kill count.
- Reset (rst high at edge): fetch_pc=rsp_pc=RESET_PC; count, outstanding, kill = 0; storage = 0. While rst high: mem_req_valid=0, inst_valid=0. Memory is reset by the same rst, so no stale responses arrive.
- Issue condition: !rst && !redirect_valid && outstanding<MAX_OUTSTANDING && (count+outstanding+kill)<DEPTH. mem_req_valid = issue condition (combinational); mem_req_addr = fetch_pc.
- Request handshake (valid&&ready): outstanding+1; fetch_pc += INST_W_BYTES, wrapping modulo 2^I_ADDR_W (0xFFE -> 0x000 at defaults).
- Withdrawal: mem_req_valid may deassert without acceptance only in a cycle where redirect_valid=1.
- Response: outstanding-1. If kill>0, kill-1 and data is dropped. Otherwise push {mem_rsp_data, rsp_pc}; rsp_pc += INST_W_BYTES with wrap. The credit rule guarantees the queue never overflows.
- Output: inst_valid = count!=0. Head is registered; there is no response-to-output bypass. Minimum latency is request accepted at T, response at T+L (L>=1), inst_valid at T+L+1.
- Pop on inst_valid&&inst_ready. Push and pop in the same cycle with the queue full or empty behave correctly; count is unchanged.
- Redirect at edge T (highest priority):
  - queue cleared; fetch_pc and rsp_pc <= redirect_addr with low log2(INST_W_BYTES) bits forced to 0;
  - kill <= outstanding after this cycle's response (a response arriving at T is dropped);
  - a pop handshake in cycle T completes first;
  - inst_valid=0 at T+1; the first request to the new address is offered at T+1.
- Back-to-back redirects are legal; each cancels the previous one.
- Pointers wrap modulo DEPTH.

Optional Feature:
Macro PREFETCH_PERF_COUNTERS_EN.
- Defined: adds outputs perf_stall_cycles (32 bits) and perf_killed_rsp (32 bits), both reset to 0 and saturating at all-ones.
  - perf_stall_cycles increments each cycle with inst_valid=0 && !rst.
  - perf_killed_rsp increments on each dropped response.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, memory L=1, always ready, inst_ready=1 -> requests 0x000, 0x002, 0x004...; first inst_valid 2 cycles after first request; inst_pc 0x000, 0x002... with matching data.
2. inst_ready=0, DEPTH=4 -> exactly 4 requests accepted, then mem_req_valid=0 and count=4. Raise inst_ready -> one new request per pop.
3. Memory L=3, MAX_OUTSTANDING=2 -> never more than 2 requests outstanding; data order preserved.
4. Redirect to 0x103 with 2 requests outstanding -> both responses dropped, queue empty next cycle, next request addr 0x102, first inst_pc=0x102.
5. fetch_pc=0xFFC, no redirect -> addresses 0xFFC, 0xFFE, 0x000; inst_pc follows the wrap.
6. Redirect in the same cycle as a pop and a response -> pop counted once, response discarded, no spurious inst_valid. With PREFETCH_PERF_COUNTERS_EN, perf_killed_rsp increments by 1.
